winograd_tile_accumulator: RTL and testbench



---
 rtl/winograd_pkg.sv | 104 ++++++++++
 rtl/winograd_tile_accumulator_mac.sv | 27 ++
 rtl/winograd_transform_units.sv | 60 ++++++
 rtl/winograd_tile_accumulator.sv | 130 +++++++++++++
 tb/tb_winograd_tile_accumulator.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/winograd_pkg.sv
// Shared types, transform matrices and arithmetic helpers for the F(4x4,3x3) tile accumulator.
// The kernel transform uses 24*G, so every transformed-domain value carries a fixed scale of 576.
package winograd_pkg;
    localparam int TILE_N = 6;
    localparam int KER_N  = 3;
    localparam int OUT_N  = 4;
    localparam int DATA_W = 16;
    localparam int SCALE  = 576;
    localparam int U_W    = 26;  // |24*G*g*(24*G)^T| <= 576 * 2^15
    localparam int V_W    = 23;  // |B^T*d*B| <= 100 * 2^15
    localparam int M_W    = 26;  // narrowed value at the 576 scale

    typedef logic [KER_N-1:0][KER_N-1:0][DATA_W-1:0]   kernel_t;
    typedef logic [TILE_N-1:0][TILE_N-1:0][DATA_W-1:0] tile_t;
    typedef logic [OUT_N-1:0][OUT_N-1:0][DATA_W-1:0]   out_t;
    typedef logic [TILE_N-1:0][TILE_N-1:0][U_W-1:0]    u_tile_t;
    typedef logic [TILE_N-1:0][TILE_N-1:0][V_W-1:0]    v_tile_t;
    typedef logic [TILE_N-1:0][TILE_N-1:0][M_W-1:0]    m_tile_t;

    typedef enum logic [2:0] {S_IDLE, S_KXF, S_TXF, S_MAC, S_NARROW, S_RXF, S_OUT} state_t;

    localparam int GK [TILE_N][KER_N] = '{'{6, 0, 0}, '{-4, -4, -4}, '{-4, 4, -4},
                                          '{1, 2, 4}, '{1, -2, 4}, '{0, 0, 24}};
    localparam int BT [TILE_N][TILE_N] = '{'{4, 0, -5, 0, 1, 0}, '{0, -4, -4, 1, 1, 0},
                                           '{0, 4, -4, -1, 1, 0}, '{0, -2, -1, 2, 1, 0},
                                           '{0, 2, -1, -2, 1, 0}, '{0, 4, 0, -5, 0, 1}};
    localparam int AT [OUT_N][TILE_N] = '{'{1, 1, 1, 1, 1, 0}, '{0, 1, -1, 2, -2, 0},
                                          '{0, 1, 1, 4, 4, 0}, '{0, 1, -1, 8, -8, 1}};

    function automatic u_tile_t ktu_f(input kernel_t k);
        int t [TILE_N][KER_N];
        int s;
        u_tile_t u;
        for (int i = 0; i < TILE_N; i++)
            for (int j = 0; j < KER_N; j++) begin
                s = 0;
                for (int q = 0; q < KER_N; q++) s += GK[i][q] * int'($signed(k[q][j]));
                t[i][j] = s;
            end
        for (int i = 0; i < TILE_N; i++)
            for (int j = 0; j < TILE_N; j++) begin
                s = 0;
                for (int q = 0; q < KER_N; q++) s += t[i][q] * GK[j][q];
                u[i][j] = U_W'(s);
            end
        return u;
    endfunction

    function automatic v_tile_t ttu_f(input tile_t d);
        int t [TILE_N][TILE_N];
        int s;
        v_tile_t v;
        for (int i = 0; i < TILE_N; i++)
            for (int j = 0; j < TILE_N; j++) begin
                s = 0;
                for (int q = 0; q < TILE_N; q++) s += BT[i][q] * int'($signed(d[q][j]));
                t[i][j] = s;
            end
        for (int i = 0; i < TILE_N; i++)
            for (int j = 0; j < TILE_N; j++) begin
                s = 0;
                for (int q = 0; q < TILE_N; q++) s += t[i][q] * BT[j][q];
                v[i][j] = V_W'(s);
            end
        return v;
    endfunction

    // Removes the 576 scale with truncation toward zero; exact whenever nothing was clamped.
    function automatic out_t rtu_f(input m_tile_t m);
        longint t [OUT_N][TILE_N];
        longint s;
        out_t y;
        for (int i = 0; i < OUT_N; i++)
            for (int j = 0; j < TILE_N; j++) begin
                s = 0;
                for (int q = 0; q < TILE_N; q++) s += longint'(AT[i][q]) * longint'($signed(m[q][j]));
                t[i][j] = s;
            end
        for (int i = 0; i < OUT_N; i++)
            for (int j = 0; j < OUT_N; j++) begin
                s = 0;
                for (int q = 0; q < TILE_N; q++) s += t[i][q] * longint'(AT[j][q]);
                y[i][j] = DATA_W'(s / longint'(SCALE));
            end
        return y;
    endfunction

    // Narrow to the 16-bit range expressed at the 576 scale; returns {clamped, value}.
    function automatic logic [M_W:0] sat_narrow(input longint x, input logic sat_en);
        longint hi, lo, span, r;
        hi   = longint'(SCALE) * 32767;
        lo   = -longint'(SCALE) * 32768;
        span = longint'(SCALE) * 65536;
        if (sat_en) begin
            if (x > hi) return {1'b1, M_W'(hi)};
            if (x < lo) return {1'b1, M_W'(lo)};
            return {1'b0, M_W'(x)};
        end
        r = x % span;
        if (r >= -lo) r -= span;
        else if (r < lo) r += span;
        return {1'b0, M_W'(r)};
    endfunction
endpackage

// File: rtl/winograd_tile_accumulator_mac.sv
// 36-lane transformed-domain multiply-accumulate; clr restarts the sum with the current product.
module winograd_mac_6x6
    import winograd_pkg::*;
#(
    parameter int ACC_W = 40
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      en,
    input  logic                                      clr,
    input  u_tile_t                                   u,
    input  v_tile_t                                   v,
    output logic [TILE_N-1:0][TILE_N-1:0][ACC_W-1:0] acc
);
    for (genvar i = 0; i < TILE_N; i++) begin : g_row
        for (genvar j = 0; j < TILE_N; j++) begin : g_lane
            logic signed [U_W+V_W-1:0] prod;
            logic signed [ACC_W-1:0]   acc_q;
            assign prod      = $signed(u[i][j]) * $signed(v[i][j]);
            assign acc[i][j] = acc_q;
            // Product is taken modulo 2^ACC_W, matching the wrapping accumulator.
            always_ff @(posedge clk or negedge rst_n)
                if (!rst_n)  acc_q <= '0;
                else if (en) acc_q <= (clr ? '0 : acc_q) + ACC_W'(prod);
        end
    end
endmodule

// File: rtl/winograd_transform_units.sv
// Start/done wrappers around the forward and reverse F(4,3) transforms; done follows start by one cycle.
module kernel_transform_unit
    import winograd_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    start,
    input  kernel_t kernel,
    output logic    done,
    output u_tile_t u
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            done <= 1'b0;
            u    <= '0;
        end else begin
            done <= start;
            if (start) u <= ktu_f(kernel);
        end
endmodule

module tile_transform_unit
    import winograd_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    start,
    input  tile_t   tile,
    output logic    done,
    output v_tile_t v
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            done <= 1'b0;
            v    <= '0;
        end else begin
            done <= start;
            if (start) v <= ttu_f(tile);
        end
endmodule

module reverse_transform_unit
    import winograd_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    start,
    input  m_tile_t m,
    output logic    done,
    output out_t    y
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            done <= 1'b0;
            y    <= '0;
        end else begin
            done <= start;
            if (start) y <= rtu_f(m);
        end
endmodule

// File: rtl/winograd_tile_accumulator.sv
// Multi-channel F(4x4,3x3) Winograd tile accumulator: per-channel transform + MAC,
// one narrowing and reverse transform per output tile, valid/ready on both sides.
module winograd_tile_accumulator
    import winograd_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int ACC_W  = 40,
    parameter  int SHIFT  = 0,
    parameter  int SAT_EN = 1,
    localparam int CH_W   = $clog2(NUM_CH) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  kernel_t         kernel_in,
    input  tile_t           tile_in,
    output logic            out_valid,
    input  logic            out_ready,
    output out_t            result_out,
    output logic [CH_W-1:0] ch_idx,
    output logic            sat_flag,
    output logic            busy
);
    state_t  state, prev_state, next_state;
    kernel_t kernel_q;
    tile_t   tile_q;
    u_tile_t u_q;
    v_tile_t v_q;
    m_tile_t m_q, m_n;
    out_t    rtu_y;
    logic    accept, last_ch, sat_any;
    logic    ktu_start, ttu_start, rtu_start, ktu_done, ttu_done, rtu_done;
    logic [TILE_N-1:0][TILE_N-1:0][ACC_W-1:0] acc;
    logic signed [63:0] wide;
    logic [M_W:0]       nr;

    assign last_ch = (ch_idx == CH_W'(NUM_CH - 1));
    assign busy    = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state      <= S_IDLE;
            prev_state <= S_IDLE;
        end else begin
            state      <= next_state;
            prev_state <= state;
        end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        ktu_start  = (state == S_KXF) && (prev_state != S_KXF);
        ttu_start  = (state == S_TXF) && (prev_state != S_TXF);
        rtu_start  = (state == S_RXF) && (prev_state != S_RXF);
        case (state)
            S_IDLE: if (in_valid && in_ready) begin
                accept     = 1'b1;
                next_state = S_KXF;
            end
            S_KXF:    if (ktu_done) next_state = S_TXF;
            S_TXF:    if (ttu_done) next_state = S_MAC;
            S_MAC:    next_state = last_ch ? S_NARROW : S_IDLE;
            S_NARROW: next_state = S_RXF;
            S_RXF:    if (rtu_done) next_state = S_OUT;
            S_OUT:    if (out_ready) next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    always_comb begin
        m_n     = '0;
        sat_any = 1'b0;
        wide    = '0;
        nr      = '0;
        for (int i = 0; i < TILE_N; i++)
            for (int j = 0; j < TILE_N; j++) begin
                wide    = 64'($signed(acc[i][j]));
                wide    = wide >>> SHIFT;
                nr      = sat_narrow(wide, SAT_EN != 0);
                m_n[i][j] = nr[M_W-1:0];
                sat_any = sat_any | nr[M_W];
            end
    end

    // Handshake flags are registered from next_state so both read 0 out of reset.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            result_out <= '0;
            ch_idx     <= '0;
            sat_flag   <= 1'b0;
            kernel_q   <= '0;
            tile_q     <= '0;
            m_q        <= '0;
        end else begin
            in_ready  <= (next_state == S_IDLE);
            out_valid <= (next_state == S_OUT);
            if (accept) begin
                kernel_q <= kernel_in;
                tile_q   <= tile_in;
            end
            if (state == S_MAC && !last_ch) ch_idx <= ch_idx + CH_W'(1);
            if (state == S_NARROW) begin
                m_q      <= m_n;
                sat_flag <= sat_flag | sat_any;
            end
            if (state == S_RXF && rtu_done) result_out <= rtu_y;
            if (state == S_OUT && out_ready) begin
                ch_idx   <= '0;
                sat_flag <= 1'b0;
            end
        end

    // The transform units' output registers serve as the U and V registers.
    kernel_transform_unit u_ktu (
        .clk(clk), .rst_n(rst_n), .start(ktu_start), .kernel(kernel_q), .done(ktu_done), .u(u_q)
    );
    tile_transform_unit u_ttu (
        .clk(clk), .rst_n(rst_n), .start(ttu_start), .tile(tile_q), .done(ttu_done), .v(v_q)
    );
    reverse_transform_unit u_rtu (
        .clk(clk), .rst_n(rst_n), .start(rtu_start), .m(m_q), .done(rtu_done), .y(rtu_y)
    );
    winograd_mac_6x6 #(.ACC_W(ACC_W)) u_mac (
        .clk(clk), .rst_n(rst_n), .en(state == S_MAC), .clr(ch_idx == '0),
        .u(u_q), .v(v_q), .acc(acc)
    );
endmodule

// File: tb/tb_winograd_tile_accumulator.sv
// Scoreboard bench: a saturating and a truncating instance share stimulus; a monitor checks each output handshake.
module tb_winograd_tile_accumulator;
    import winograd_pkg::*;
    localparam int NUM_CH = 4;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic    in_valid = 1'b0, out_ready = 1'b1;
    kernel_t kernel_in = '0;
    tile_t   tile_in = '0;
    logic    in_ready, out_valid, sat_flag, busy;
    logic    in_ready_t, out_valid_t, sat_flag_t, busy_t;
    out_t    result_out, result_t;
    logic [2:0] ch_idx, ch_idx_t;

    winograd_tile_accumulator #(.NUM_CH(NUM_CH), .ACC_W(40), .SHIFT(0), .SAT_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .kernel_in(kernel_in), .tile_in(tile_in), .out_valid(out_valid), .out_ready(out_ready),
        .result_out(result_out), .ch_idx(ch_idx), .sat_flag(sat_flag), .busy(busy)
    );
    winograd_tile_accumulator #(.NUM_CH(NUM_CH), .ACC_W(40), .SHIFT(0), .SAT_EN(0)) dut_t (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_t),
        .kernel_in(kernel_in), .tile_in(tile_in), .out_valid(out_valid_t), .out_ready(out_ready),
        .result_out(result_t), .ch_idx(ch_idx_t), .sat_flag(sat_flag_t), .busy(busy_t)
    );

    typedef struct {
        out_t r_sat;
        out_t r_trunc;
        logic f_sat;
        logic f_trunc;
    } exp_t;
    exp_t sb[$];
    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    function automatic out_t fill_o(input int v);
        out_t o;
        for (int r = 0; r < OUT_N; r++) for (int c = 0; c < OUT_N; c++) o[r][c] = DATA_W'(v);
        return o;
    endfunction
    function automatic kernel_t fill_k(input int v);
        kernel_t k;
        for (int r = 0; r < KER_N; r++) for (int c = 0; c < KER_N; c++) k[r][c] = DATA_W'(v);
        return k;
    endfunction
    function automatic tile_t fill_t(input int v);
        tile_t t;
        for (int r = 0; r < TILE_N; r++) for (int c = 0; c < TILE_N; c++) t[r][c] = DATA_W'(v);
        return t;
    endfunction
    function automatic exp_t mk(input out_t s, input out_t t, input logic fs, input logic ft);
        exp_t e;
        e.r_sat = s; e.r_trunc = t; e.f_sat = fs; e.f_trunc = ft;
        return e;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            chk("sb_nonempty", 256'(sb.size() != 0), 256'(1));
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("result_sat", result_out, e.r_sat);
                chk("result_trunc", result_t, e.r_trunc);
                chk("sat_flag", 256'(sat_flag), 256'(e.f_sat));
                chk("sat_flag_trunc", 256'(sat_flag_t), 256'(e.f_trunc));
                chk("out_valid_trunc", 256'(out_valid_t), 256'(1));
            end
        end
    end

    task automatic send_pair(input kernel_t k, input tile_t t, input int ch);
        int n = 0;
        @(posedge clk); #1;
        kernel_in = k; tile_in = t; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", 256'(in_ready), 256'(1));
        chk("ch_idx", 256'(ch_idx), 256'(ch));
        chk("ch_idx_trunc", 256'(ch_idx_t), 256'(ch));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_tile(input kernel_t ks[NUM_CH], input tile_t ts[NUM_CH], input exp_t e);
        sb.push_back(e);
        for (int c = 0; c < NUM_CH; c++) send_pair(ks[c], ts[c], c);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 256'(sb.size()), 256'(0));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_in_ready"}, 256'(in_ready), 256'(0));
        chk({tag, "_out_valid"}, 256'(out_valid), 256'(0));
        chk({tag, "_result"}, result_out, 256'(0));
        chk({tag, "_ch_idx"}, 256'(ch_idx), 256'(0));
        chk({tag, "_sat_flag"}, 256'(sat_flag), 256'(0));
        chk({tag, "_busy"}, 256'(busy), 256'(0));
        chk({tag, "_busy_trunc"}, 256'(busy_t), 256'(0));
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin : stim
        kernel_t ks[NUM_CH];
        tile_t   ts[NUM_CH];
        kernel_t kc;
        tile_t   tp;
        out_t    eo;
        int      n;

        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Centre-tap kernel on channel 0 only: output is the shifted tile interior.
        kc = '0; kc[1][1] = 16'd1;
        for (int i = 0; i < TILE_N; i++) for (int j = 0; j < TILE_N; j++) tp[i][j] = DATA_W'(6 * i + j);
        for (int r = 0; r < OUT_N; r++) for (int c = 0; c < OUT_N; c++) eo[r][c] = DATA_W'(6 * (r + 1) + c + 1);
        ks = '{kc, '0, '0, '0};
        ts = '{tp, fill_t(100), fill_t(100), fill_t(100)};
        send_tile(ks, ts, mk(eo, eo, 1'b0, 1'b0));

        for (int c = 0; c < NUM_CH; c++) begin ks[c] = fill_k(1); ts[c] = fill_t(1); end
        send_tile(ks, ts, mk(fill_o(36), fill_o(36), 1'b0, 1'b0));

        kc = '0; kc[1][1] = 16'hFFFF;
        ks = '{kc, '0, '0, '0};
        ts = '{fill_t(100), fill_t(7), fill_t(7), fill_t(7)};
        send_tile(ks, ts, mk(fill_o(-100), fill_o(-100), 1'b0, 1'b0));

        ks = '{fill_k(-2), '0, '0, '0};
        ts = '{fill_t(300), fill_t(-5), fill_t(-5), fill_t(-5)};
        send_tile(ks, ts, mk(fill_o(-5400), fill_o(-5400), 1'b0, 1'b0));
        drain();

        // Back-pressure: result must hold for 10 cycles with the input side closed.
        out_ready = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin ks[c] = fill_k(1); ts[c] = fill_t(1); end
        send_tile(ks, ts, mk(fill_o(36), fill_o(36), 1'b0, 1'b0));
        n = 0;
        while (!out_valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("bp_wait", 256'(out_valid), 256'(1));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 256'(out_valid), 256'(1));
            chk("bp_result", result_out, fill_o(36));
            chk("bp_in_ready", 256'(in_ready), 256'(0));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_in_ready", 256'(in_ready), 256'(1));
        chk("bp_release_out_valid", 256'(out_valid), 256'(0));

        // True sum 4*9*127*255 = 1165860: clamps to 32767, or wraps to -13788.
        for (int c = 0; c < NUM_CH; c++) begin ks[c] = fill_k(127); ts[c] = fill_t(255); end
        send_tile(ks, ts, mk(fill_o(32767), fill_o(-13788), 1'b1, 1'b0));
        drain();

        // Abort during the kernel transform of channel 2.
        send_pair(fill_k(5), fill_t(9), 0);
        send_pair(fill_k(5), fill_t(9), 1);
        send_pair(fill_k(5), fill_t(9), 2);
        chk("abort_busy", 256'(busy), 256'(1));
        rst_n = 1'b0;
        #1;
        chk_reset("abort");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        for (int c = 0; c < NUM_CH; c++) begin ks[c] = fill_k(1); ts[c] = fill_t(1); end
        send_tile(ks, ts, mk(fill_o(36), fill_o(36), 1'b0, 1'b0));
        drain();

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
